uart_stream_gen_chk: RTL and testbench

Synthesizable UART traffic generator and checker for board-level soak testing of the triple-buffered UART/SRAM path. The generator feeds a deterministic byte pattern into an external uart_tx through its DV/done handshake and honours flow-control hold. The checker locks onto the byte stream returned from an external uart_rx, then counts mismatches, received bytes and stalls. It is the parametrised successor of the bench-only incrementing-byte stimulus, now in RTL with burst length, pattern mode and error accounting.

---
 rtl/uart_stream_gen_chk.sv | 165 ++++++++++++++++
 tb/tb_uart_stream_gen_chk.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_stream_gen_chk.sv
// UART soak-test pattern generator (DV/done handshake to uart_tx) and resyncing stream checker.
// Define UART_GEN_LFSR_EN to build the 8-bit LFSR pattern selected by mode=1.
module uart_stream_gen_chk #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned COUNT_W        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned SEED           = 0
) (
    input  logic               clk_in,
    input  logic               button_reset,
    input  logic               enable,
    input  logic               clear,
    input  logic               mode,
    input  logic [COUNT_W-1:0] burst_len,
    input  logic               tx_hold,
    output logic               tx_dv,
    output logic [DATA_W-1:0]  tx_byte,
    input  logic               tx_done,
    input  logic               rx_dv,
    input  logic [DATA_W-1:0]  rx_byte,
    output logic               gen_busy,
    output logic               burst_done,
    output logic               locked,
    output logic               timeout,
    output logic [COUNT_W-1:0] tx_count,
    output logic [COUNT_W-1:0] rx_count,
    output logic [COUNT_W-1:0] err_count
);

    localparam int unsigned       TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DATA_W-1:0] SEED_V     = DATA_W'(SEED);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {G_IDLE, G_BUSY} gen_state_t;
    typedef enum logic {C_HUNT, C_LOCK} chk_state_t;

    gen_state_t         r_gen_state;
    chk_state_t         r_chk_state;
    logic               r_tx_dv;
    logic [DATA_W-1:0]  r_tx_byte;
    logic               r_gen_busy;
    logic               r_burst_done;
    logic [COUNT_W-1:0] r_tx_count;
    logic [DATA_W-1:0]  r_expected;
    logic [TIMER_W-1:0] r_timer;
    logic               r_locked;
    logic               r_timeout;
    logic [COUNT_W-1:0] r_rx_count;
    logic [COUNT_W-1:0] r_err_count;
    logic [COUNT_W-1:0] w_tx_count_inc;

    assign w_tx_count_inc = r_tx_count + 1'b1;

`ifdef UART_GEN_LFSR_EN
    // x^8+x^6+x^5+x^4+1, shift left; zero would lock up so it is forced to 01.
    function automatic logic [DATA_W-1:0] f_next(input logic [DATA_W-1:0] x);
        logic [7:0] v;
        v = 8'(x);
        if (mode && (DATA_W == 8)) begin
            if (v == 8'h00) return DATA_W'(8'h01);
            return DATA_W'({v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]});
        end
        return x + 1'b1;
    endfunction
`else
    logic w_unused_mode;
    assign w_unused_mode = mode;

    function automatic logic [DATA_W-1:0] f_next(input logic [DATA_W-1:0] x);
        return x + 1'b1;
    endfunction
`endif

    always_ff @(posedge clk_in or negedge button_reset) begin
        if (!button_reset) begin
            r_gen_state  <= G_IDLE;
            r_tx_dv      <= 1'b0;
            r_tx_byte    <= SEED_V;
            r_gen_busy   <= 1'b0;
            r_burst_done <= 1'b0;
            r_tx_count   <= '0;
        end else if (clear) begin
            r_gen_state  <= G_IDLE;
            r_tx_dv      <= 1'b0;
            r_tx_byte    <= SEED_V;
            r_gen_busy   <= 1'b0;
            r_burst_done <= 1'b0;
            r_tx_count   <= '0;
        end else begin
            r_tx_dv <= 1'b0;
            case (r_gen_state)
                G_IDLE: begin
                    if (enable && !tx_hold && !r_burst_done) begin
                        r_tx_dv     <= 1'b1;
                        r_gen_busy  <= 1'b1;
                        r_gen_state <= G_BUSY;
                    end
                end
                G_BUSY: begin
                    // hold and enable are ignored here so an in-flight byte always completes
                    if (tx_done) begin
                        r_tx_count  <= w_tx_count_inc;
                        r_tx_byte   <= f_next(r_tx_byte);
                        r_gen_busy  <= 1'b0;
                        r_gen_state <= G_IDLE;
                        if ((burst_len != '0) && (w_tx_count_inc == burst_len)) begin
                            r_burst_done <= 1'b1;
                        end
                    end
                end
                default: r_gen_state <= G_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge button_reset) begin
        if (!button_reset) begin
            r_chk_state <= C_HUNT;
            r_expected  <= '0;
            r_timer     <= '0;
            r_locked    <= 1'b0;
            r_timeout   <= 1'b0;
            r_rx_count  <= '0;
            r_err_count <= '0;
        end else if (clear) begin
            r_chk_state <= C_HUNT;
            r_expected  <= '0;
            r_timer     <= '0;
            r_locked    <= 1'b0;
            r_timeout   <= 1'b0;
            r_rx_count  <= '0;
            r_err_count <= '0;
        end else if (rx_dv) begin
            // Always resync on the received byte so a single drop costs exactly one error.
            r_rx_count  <= r_rx_count + 1'b1;
            r_expected  <= f_next(rx_byte);
            r_timer     <= '0;
            r_locked    <= 1'b1;
            r_chk_state <= C_LOCK;
            if ((r_chk_state == C_LOCK) && (rx_byte != r_expected) && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end else if (r_chk_state == C_LOCK) begin
            if (r_timer == TIMER_LAST) begin
                r_timeout   <= 1'b1;
                r_locked    <= 1'b0;
                r_timer     <= '0;
                r_chk_state <= C_HUNT;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    assign tx_dv      = r_tx_dv;
    assign tx_byte    = r_tx_byte;
    assign gen_busy   = r_gen_busy;
    assign burst_done = r_burst_done;
    assign tx_count   = r_tx_count;
    assign locked     = r_locked;
    assign timeout    = r_timeout;
    assign rx_count   = r_rx_count;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_uart_stream_gen_chk.sv
// Bench for uart_stream_gen_chk: emulated uart_tx with loopback into the checker, compared each
// cycle against a behavioural model; follows UART_GEN_LFSR_EN like the design.
`timescale 1ns/1ps
module tb_uart_stream_gen_chk;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int TO = 50;

    logic          clk_in = 1'b0;
    logic          button_reset, enable, clear, mode, tx_hold, tx_done, rx_dv;
    logic [CW-1:0] burst_len;
    logic [DW-1:0] rx_byte;
    logic          tx_dv, gen_busy, burst_done, locked, timeout;
    logic [DW-1:0] tx_byte;
    logic [CW-1:0] tx_count, rx_count, err_count;

    uart_stream_gen_chk #(
        .DATA_W(DW), .COUNT_W(CW), .TIMEOUT_CYCLES(TO), .SEED(0)
    ) dut (
        .clk_in(clk_in), .button_reset(button_reset), .enable(enable), .clear(clear),
        .mode(mode), .burst_len(burst_len), .tx_hold(tx_hold), .tx_dv(tx_dv),
        .tx_byte(tx_byte), .tx_done(tx_done), .rx_dv(rx_dv), .rx_byte(rx_byte),
        .gen_busy(gen_busy), .burst_done(burst_done), .locked(locked), .timeout(timeout),
        .tx_count(tx_count), .rx_count(rx_count), .err_count(err_count)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    // Behavioural model state
    int m_busy, m_dv, m_byte, m_txc, m_bdone, m_locked, m_exp, m_rxc, m_err, m_to, m_since;

    // Environment: uart_tx emulation and loopback pipe
    typedef struct {int b; int due;} lb_t;
    lb_t lbq[$];
    int  txlog[$];
    int  tx_cnt = 0, cap_byte = 0, lb_num = 0, drop_idx = -1, corrupt_pct = 0;
    int  lb_delay = 2, lat_lo = 1, lat_hi = 4;
    bit  rx_stop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int m_next(input int x, input logic md);
`ifdef UART_GEN_LFSR_EN
        if (md) begin
            if (x == 0) return 1;
            return ((x << 1) & 255) | (((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1);
        end
`endif
        return (x + 1) % 256;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_dv = 0; m_byte = 0; m_txc = 0; m_bdone = 0;
        m_locked = 0; m_exp = 0; m_rxc = 0; m_err = 0; m_to = 0; m_since = 0;
    endtask

    task automatic model_step();
        if (clear) begin
            model_reset();
            return;
        end
        m_dv = 0;
        if (m_busy == 0) begin
            if (enable && !tx_hold && m_bdone == 0) begin
                m_dv = 1;
                m_busy = 1;
            end
        end else if (tx_done) begin
            m_txc  = (m_txc + 1) % 256;
            m_byte = m_next(m_byte, mode);
            m_busy = 0;
            if (burst_len != 0 && m_txc == int'(burst_len)) m_bdone = 1;
        end
        if (rx_dv) begin
            m_rxc = (m_rxc + 1) % 256;
            if (m_locked != 0 && int'(rx_byte) != m_exp) m_err = (m_err == 255) ? 255 : m_err + 1;
            m_exp = m_next(int'(rx_byte), mode);
            m_locked = 1;
            m_since = 0;
        end else if (m_locked != 0) begin
            m_since++;
            if (m_since >= TO) begin
                m_to = 1;
                m_locked = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("tx_dv", 32'(tx_dv), m_dv);
        chk("tx_byte", 32'(tx_byte), m_byte);
        chk("gen_busy", 32'(gen_busy), m_busy);
        chk("burst_done", 32'(burst_done), m_bdone);
        chk("tx_count", 32'(tx_count), m_txc);
        chk("locked", 32'(locked), m_locked);
        chk("timeout", 32'(timeout), m_to);
        chk("rx_count", 32'(rx_count), m_rxc);
        chk("err_count", 32'(err_count), m_err);
    endtask

    task automatic env_drive();
        lb_t e;
        tx_done = 1'b0;
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                tx_done = 1'b1;
                if (!rx_stop && lb_num != drop_idx) begin
                    e.b = cap_byte;
                    if (int'($urandom_range(0, 99)) < corrupt_pct) e.b = e.b ^ (1 << $urandom_range(0, 7));
                    e.due = cyc + lb_delay;
                    lbq.push_back(e);
                end
                lb_num++;
            end
        end
        if (tx_dv === 1'b1) begin
            tx_cnt   = int'($urandom_range(lat_lo, lat_hi));
            cap_byte = int'(tx_byte);
            txlog.push_back(int'(tx_byte));
        end
        rx_dv   = 1'b0;
        rx_byte = 8'($urandom);
        if (lbq.size() > 0 && lbq[0].due <= cyc) begin
            e = lbq.pop_front();
            rx_dv   = 1'b1;
            rx_byte = 8'(e.b);
        end
    endtask

    task automatic cycle();
        @(posedge clk_in);
        cyc++;
        if (!button_reset) model_reset();
        else model_step();
        #1;
        compare_all();
        env_drive();
    endtask

    task automatic flush_env();
        lbq.delete(); txlog.delete();
        tx_cnt = 0; lb_num = 0; drop_idx = -1; corrupt_pct = 0; rx_stop = 0;
        tx_done = 1'b0; rx_dv = 1'b0;
    endtask

    task automatic drain_clear();
        enable = 1'b0; tx_hold = 1'b0; rx_stop = 0;
        repeat (30) cycle();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        flush_env();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, c, seen;
        int exp_mode[6];
        button_reset = 1'b0; enable = 1'b0; clear = 1'b0; mode = 1'b0; tx_hold = 1'b0;
        tx_done = 1'b0; rx_dv = 1'b0; rx_byte = '0; burst_len = '0;
        model_reset();
        repeat (3) cycle();
        chk("reset tx_byte", 32'(tx_byte), 0);
        chk("reset locked", 32'(locked), 0);
        button_reset = 1'b1;

        // Burst of 5 in loopback
        drain_clear();
        burst_len = 8'd5; enable = 1'b1; lat_lo = 1; lat_hi = 4;
        n = 0;
        while (m_rxc != 5 && n < 300) begin cycle(); n++; end
        chk("burst5 wait", 32'(n < 300), 1);
        chk("burst5 tx_count", 32'(tx_count), 5);
        chk("burst5 burst_done", 32'(burst_done), 1);
        chk("burst5 rx_count", 32'(rx_count), 5);
        chk("burst5 err_count", 32'(err_count), 0);
        chk("burst5 locked", 32'(locked), 1);
        chk("burst5 byte count", txlog.size(), 5);
        for (int i = 0; i < 5 && i < txlog.size(); i++) chk("burst5 byte", txlog[i], i);

        // Hold raised while byte 03 is in flight
        drain_clear();
        burst_len = 8'd0; enable = 1'b1; lat_lo = 3; lat_hi = 3;
        n = 0;
        while (!(m_busy == 1 && m_byte == 3) && n < 300) begin cycle(); n++; end
        chk("hold wait", 32'(n < 300), 1);
        tx_hold = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (tx_dv === 1'b1) seen++;
        end
        chk("hold no tx_dv", seen, 0);
        chk("hold byte03 completed", 32'(tx_count), 4);
        tx_hold = 1'b0;
        cycle();
        chk("release tx_dv", 32'(tx_dv), 1);
        chk("release tx_byte", 32'(tx_byte), 4);

        // Drop byte 07 out of 00..0F
        drain_clear();
        burst_len = 8'd16; enable = 1'b1; lat_lo = 1; lat_hi = 4; drop_idx = 7;
        n = 0;
        while (m_rxc != 15 && n < 500) begin cycle(); n++; end
        repeat (10) cycle();
        chk("drop wait", 32'(n < 500), 1);
        chk("drop err_count", 32'(err_count), 1);
        chk("drop rx_count", 32'(rx_count), 15);
        chk("drop locked", 32'(locked), 1);
        chk("drop tx_count", 32'(tx_count), 16);

        // Stall timeout and relock
        drain_clear();
        burst_len = 8'd3; enable = 1'b1;
        n = 0;
        while (m_rxc != 3 && n < 300) begin cycle(); n++; end
        chk("stall wait", 32'(n < 300), 1);
        c = 0;
        while (timeout !== 1'b1 && c < 200) begin cycle(); c++; end
        chk("timeout latency", c, TO);
        chk("timeout locked", 32'(locked), 0);
        lbq.push_back('{b: 8'h55, due: cyc});
        cycle(); cycle();
        chk("relock locked", 32'(locked), 1);
        chk("relock err_count", 32'(err_count), 0);
        chk("relock timeout sticky", 32'(timeout), 1);
        chk("relock rx_count", 32'(rx_count), 4);

        // Pattern mode 1
        drain_clear();
        mode = 1'b1; burst_len = 8'd6; enable = 1'b1;
`ifdef UART_GEN_LFSR_EN
        exp_mode = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
`else
        exp_mode = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
`endif
        n = 0;
        while (m_rxc != 6 && n < 300) begin cycle(); n++; end
        chk("mode wait", 32'(n < 300), 1);
        chk("mode byte count", txlog.size(), 6);
        for (int i = 0; i < 6 && i < txlog.size(); i++) chk("mode byte", txlog[i], exp_mode[i]);
        chk("mode err_count", 32'(err_count), 0);
        mode = 1'b0;

        // 300 mismatching bytes saturate the error counter
        drain_clear();
        for (int i = 0; i < 300; i++) begin
            lbq.push_back('{b: 0, due: cyc});
            cycle(); cycle();
        end
        repeat (3) cycle();
        chk("saturate err_count", 32'(err_count), 255);
        chk("saturate rx_count", 32'(rx_count), 300 % 256);

        // Randomised soak
        drain_clear();
        enable = 1'b1; corrupt_pct = 5; lat_lo = 1; lat_hi = 6;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 5) enable = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 99) < 2) mode = ~mode;
            if ($urandom_range(0, 99) < 10) tx_hold = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 1) burst_len = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 30));
            clear = ($urandom_range(0, 999) < 5);
            if ($urandom_range(0, 99) < 1) rx_stop = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) < 3 && drop_idx < lb_num) drop_idx = lb_num + int'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 2) lb_delay = int'($urandom_range(0, 4));
            cycle();
        end
        clear = 1'b0; mode = 1'b0;

        // Asynchronous reset in the middle of a transfer
        drain_clear();
        burst_len = 8'd0; enable = 1'b1; lat_lo = 4; lat_hi = 4;
        n = 0;
        while (!(m_busy == 1 && m_txc >= 2) && n < 300) begin cycle(); n++; end
        chk("reset-busy wait", 32'(n < 300), 1);
        #2 button_reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("async reset tx_byte", 32'(tx_byte), 0);
        chk("async reset gen_busy", 32'(gen_busy), 0);
        chk("async reset tx_count", 32'(tx_count), 0);
        flush_env();
        repeat (3) cycle();
        button_reset = 1'b1;
        repeat (20) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
